// File: rtl/adderc_seq_pkg.sv
// Shared types and default sizing for the word-serial adder/subtractor.
package adderc_seq_pkg;

  localparam int unsigned DefWidth  = 16;
  localparam int unsigned DefNwords = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/adderc_seq_adderc.sv
// adderc: one WIDTH-bit add step with carry in/out. When sub_nadd is set, b is
// inverted here; the caller supplies the +1 through cin. IS_REG_OUT selects a
// registered or purely combinational result.
module adderc
  import adderc_seq_pkg::*;
#(
  parameter int unsigned WIDTH      = DefWidth,
  parameter bit          IS_REG_OUT = 1'b0
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub_nadd,
  output logic [WIDTH-1:0] out,
  output logic             cout
);

  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_sum;

  assign w_b_eff = sub_nadd ? ~b : b;
  assign w_sum   = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, cin};

  if (IS_REG_OUT) begin : g_reg
    logic [WIDTH-1:0] r_out;
    logic             r_cout;

    // Register sum and carry.
    always_ff @(posedge clk) begin
      if (srst) begin
        r_out  <= '0;
        r_cout <= 1'b0;
      end else begin
        r_out  <= w_sum[WIDTH-1:0];
        r_cout <= w_sum[WIDTH];
      end
    end

    assign out  = r_out;
    assign cout = r_cout;
  end else begin : g_comb
    // Clock and reset are only needed by the registered variant.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ srst;

    assign out  = w_sum[WIDTH-1:0];
    assign cout = w_sum[WIDTH];
  end

endmodule

// File: rtl/adderc_seq.sv
// adderc_seq: word-serial W = WIDTH*NWORDS bit adder/subtractor, LSW first,
// one word per enabled cycle, valid/ready handshakes on both sides.
// Optional signed-overflow output ovf when ADDERC_SEQ_OVERFLOW_EN is defined.
module adderc_seq
  import adderc_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned NWORDS = DefNwords
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     enable,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     sub_nadd,
  input  logic [WIDTH*NWORDS-1:0]  a,
  input  logic [WIDTH*NWORDS-1:0]  b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH*NWORDS-1:0]  out,
  output logic                     cout
`ifdef ADDERC_SEQ_OVERFLOW_EN
  ,
  output logic                     ovf
`endif
);

  localparam int unsigned IdxW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  state_e r_state, w_state_next;

  logic [NWORDS-1:0][WIDTH-1:0] r_a;
  logic [NWORDS-1:0][WIDTH-1:0] r_b;   // already inverted for subtraction
  logic [NWORDS-1:0][WIDTH-1:0] r_out;
  logic                         r_carry;
  logic                         r_cout;
  logic [IdxW-1:0]              r_idx;

  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_last;

  assign w_last = (r_idx == IdxW'(NWORDS - 1));

  adderc #(
    .WIDTH      (WIDTH),
    .IS_REG_OUT (1'b0)
  ) u_adderc (
    .clk      (clk),
    .srst     (srst),
    .a        (r_a[r_idx]),
    .b        (r_b[r_idx]),
    .cin      (r_carry),
    .sub_nadd (1'b0),
    .out      (w_sum),
    .cout     (w_cout)
  );

  // State register; enable low freezes the FSM.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_state <= StIdle;
    end else if (enable) begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (in_valid)  w_state_next = StRun;
      StRun:   if (w_last)    w_state_next = StDone;
      StDone:  if (out_ready) w_state_next = StIdle;
      default:                w_state_next = StIdle;
    endcase
  end

  // Operand capture at acceptance, then one word per enabled RUN cycle.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_out   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
    end else if (enable) begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= sub_nadd ? ~b : b;
            r_carry <= sub_nadd;  // +1 completes the two's complement of b
            r_idx   <= '0;
          end
        end
        StRun: begin
          r_out[r_idx] <= w_sum;
          r_carry      <= w_cout;
          r_idx        <= r_idx + 1'b1;
          if (w_last) r_cout <= w_cout;
        end
        default: ;
      endcase
    end
  end

`ifdef ADDERC_SEQ_OVERFLOW_EN
  logic r_ovf;

  // Signed overflow judged on the MSW step from the operand and sum sign bits.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_ovf <= 1'b0;
    end else if (enable) begin
      if (r_state == StIdle && in_valid) begin
        r_ovf <= 1'b0;
      end else if (r_state == StRun && w_last) begin
        r_ovf <= (r_a[NWORDS-1][WIDTH-1] == r_b[NWORDS-1][WIDTH-1]) &&
                 (w_sum[WIDTH-1] != r_a[NWORDS-1][WIDTH-1]);
      end
    end
  end

  assign ovf = r_ovf;
`endif

  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StDone);
  assign out       = r_out;
  assign cout      = r_cout;

endmodule
